// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: segment map defaults,
// segment-select encoding, FSM states and the byte-merge helper.
package data_mem_responder_pkg;

  localparam logic [31:0] TEXT_BASE      = 32'h0000_0000;
  localparam logic [31:0] DATA_BASE_DEF  = 32'h0000_0400;
  localparam logic [31:0] STACK_TOP_DEF  = 32'h007F_FFFC;

  // Word returned as load data whenever the address hits no segment.
  localparam logic [31:0] UNDEFINED_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    SEG_TEXT  = 2'd0,
    SEG_DATA  = 2'd1,
    SEG_STACK = 2'd2,
    SEG_NONE  = 2'd3
  } segSel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } respState_t;

  // Replace only the bytes of oldWord whose enable bit is set.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  byteEn);
    logic [31:0] merged;
    merged = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (byteEn[b]) merged[8*b +: 8] = newWord[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_mem_responder_segdecode.sv
// Combinational address-to-segment decoder. Returns the segment select and
// the word index inside that segment; the stack is indexed downward from its top.
module mem_segment_decode
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned TEXT_WORDS  = 256,
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEF,
  parameter int unsigned DATA_WORDS  = 256,
  parameter logic [31:0] STACK_TOP   = STACK_TOP_DEF,
  parameter int unsigned STACK_WORDS = 512
) (
  input  logic [31:0] addr,
  output logic [1:0]  seg,
  output logic [31:0] index
);

  localparam logic [31:0] TEXT_LAST = TEXT_BASE + 32'(TEXT_WORDS * 4 - 4);
  localparam logic [31:0] DATA_LAST = DATA_BASE + 32'(DATA_WORDS * 4 - 4);
  localparam logic [31:0] STACK_LOW = STACK_TOP - 32'((STACK_WORDS - 1) * 4);

  localparam bit OVERLAP =
      ((TEXT_BASE <= DATA_LAST) && (DATA_BASE <= TEXT_LAST)) ||
      ((TEXT_BASE <= STACK_TOP) && (STACK_LOW <= TEXT_LAST)) ||
      ((DATA_BASE <= STACK_TOP) && (STACK_LOW <= DATA_LAST));

  generate
    if (OVERLAP) begin : gSegmentOverlap
      $error("mem_segment_decode: text, data and stack segments overlap");
    end
  endgenerate

  logic [31:0] wordAddr;
  logic        unusedByteOffset;

  assign wordAddr         = {addr[31:2], 2'b00};
  assign unusedByteOffset = ^addr[1:0];

  // Text is tested relative to its base so a non-zero base needs no rework.
  always_comb begin
    seg   = SEG_NONE;
    index = 32'h0;
    if ((wordAddr - TEXT_BASE) <= (TEXT_LAST - TEXT_BASE)) begin
      seg   = SEG_TEXT;
      index = (wordAddr - TEXT_BASE) >> 2;
    end else if ((wordAddr >= DATA_BASE) && (wordAddr <= DATA_LAST)) begin
      seg   = SEG_DATA;
      index = (wordAddr - DATA_BASE) >> 2;
    end else if ((wordAddr >= STACK_LOW) && (wordAddr <= STACK_TOP)) begin
      seg   = SEG_STACK;
      index = (STACK_TOP - wordAddr) >> 2;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time,
// commits it after LATENCY cycles and holds the response until taken.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          LATENCY     = 2,
  parameter int unsigned TEXT_WORDS  = 256,
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEF,
  parameter int unsigned DATA_WORDS  = 256,
  parameter logic [31:0] STACK_TOP   = STACK_TOP_DEF,
  parameter int unsigned STACK_WORDS = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned MEM_WORDS    = TEXT_WORDS + DATA_WORDS + STACK_WORDS;
  localparam int          MEM_AW       = $clog2(MEM_WORDS);
  localparam bit          SINGLE_CYCLE = (LATENCY == 1);

  generate
    if ((LATENCY < 1) || (LATENCY > 15)) begin : gBadLatency
      $error("data_mem_responder: LATENCY must be in 1..15");
    end
  endgenerate

  respState_t  state, nextState;
  logic [3:0]  count;
  logic        capWrite;
  logic [31:0] capAddr, capWdata;
  logic [3:0]  capBe;
  logic [31:0] rdataReg;
  logic        errReg;

  logic        accept, commitNow;
  logic        opWrite;
  logic [31:0] opAddr, opWdata;
  logic [3:0]  opBe;
  logic [1:0]  segRaw;
  segSel_t     segSel;
  logic [31:0] segIndex, flatIdx;
  logic [MEM_AW-1:0] memIdx;
  logic        unusedFlatBits;

  logic [31:0] mem [MEM_WORDS];

  assign accept    = req_valid && req_ready;
  assign commitNow = (SINGLE_CYCLE && (state == IDLE) && accept) ||
                     ((state == WAIT) && (count == 4'd0));

  // With a one-cycle latency the commit happens on the accepting edge, so the
  // live request is used; otherwise the captured copy is.
  always_comb begin
    opWrite = capWrite;
    opAddr  = capAddr;
    opWdata = capWdata;
    opBe    = capBe;
    if (state == IDLE) begin
      opWrite = req_write;
      opAddr  = req_addr;
      opWdata = req_wdata;
      opBe    = req_be;
    end
  end

  mem_segment_decode #(
    .TEXT_WORDS (TEXT_WORDS),
    .DATA_BASE  (DATA_BASE),
    .DATA_WORDS (DATA_WORDS),
    .STACK_TOP  (STACK_TOP),
    .STACK_WORDS(STACK_WORDS)
  ) uDecode (
    .addr (opAddr),
    .seg  (segRaw),
    .index(segIndex)
  );

  assign segSel = segSel_t'(segRaw);

  // All three segments share one array laid out text, data, stack.
  always_comb begin
    flatIdx = 32'h0;
    unique case (segSel)
      SEG_TEXT:  flatIdx = segIndex;
      SEG_DATA:  flatIdx = 32'(TEXT_WORDS) + segIndex;
      SEG_STACK: flatIdx = 32'(TEXT_WORDS + DATA_WORDS) + segIndex;
      default:   flatIdx = 32'h0;
    endcase
  end

  assign memIdx         = flatIdx[MEM_AW-1:0];
  assign unusedFlatBits = ^flatIdx[31:MEM_AW];

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (accept) nextState = SINGLE_CYCLE ? RESP : WAIT;
      WAIT:    if (count == 4'd0) nextState = RESP;
      RESP:    if (resp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Handshake outputs; no request is accepted while reset is held.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    if (reset_n && (state == IDLE)) req_ready = 1'b1;
    if (state == RESP) resp_valid = 1'b1;
  end

  // Request capture, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count    <= 4'd0;
      capWrite <= 1'b0;
      capAddr  <= 32'h0;
      capWdata <= 32'h0;
      capBe    <= 4'h0;
      rdataReg <= 32'h0;
      errReg   <= 1'b0;
    end else begin
      if (accept) begin
        capWrite <= req_write;
        capAddr  <= req_addr;
        capWdata <= req_wdata;
        capBe    <= req_be;
        count    <= 4'(LATENCY - 1);
      end else if ((state == WAIT) && (count != 4'd0)) begin
        count <= count - 4'd1;
      end
      if (commitNow) begin
        if (segSel == SEG_NONE) begin
          rdataReg <= UNDEFINED_WORD;
          errReg   <= 1'b1;
        end else begin
          rdataReg <= opWrite ? 32'h0 : mem[memIdx];
          errReg   <= 1'b0;
        end
      end
    end
  end

  // Array is not reset; a store pending when reset arrives never commits.
  always_ff @(posedge clk) begin
    if (reset_n && commitNow && opWrite && (segSel != SEG_NONE)) begin
      mem[memIdx] <= mergeBytes(mem[memIdx], opWdata, opBe);
    end
  end

  assign resp_rdata = rdataReg;
  assign resp_err   = errReg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder with default parameters.
module tb_data_mem_responder;

  localparam int LAT = 2;
  localparam logic [31:0] UNDEF = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int compared   = 0;
  int mismatched = 0;

  data_mem_responder #(.LATENCY(LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One full transaction: request, latency measurement, optional hold of
  // resp_ready low for 'hold' cycles, then the response handshake.
  task automatic applyStimulus(input string tag, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input int hold,
                               output logic [31:0] rdata, output logic err);
    int waitCnt;
    int lat;
    @(negedge clk);
    waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({tag, "_reqReady"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT));
    rdata = resp_rdata;
    err   = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, "_holdValid"}, {31'd0, resp_valid}, 32'd1);
      checkOutput({tag, "_holdRdata"}, resp_rdata, rdata);
      checkOutput({tag, "_holdReqReady"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_be     = 4'h0;
    resp_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_respValid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_respErr", {31'd0, resp_err}, 32'd0);
    checkOutput("rst_respRdata", resp_rdata, 32'h0);
    checkOutput("rst_reqReady", {31'd0, req_ready}, 32'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("idle_reqReady", {31'd0, req_ready}, 32'd1);

    // Store with unaligned low bits then load the aligned word.
    applyStimulus("st401", 1'b1, 32'h0000_0401, 32'h0000_0001, 4'hF, 0, rd, er);
    checkOutput("st401_err", {31'd0, er}, 32'd0);
    checkOutput("st401_rdata", rd, 32'h0);
    applyStimulus("ld400", 1'b0, 32'h0000_0400, 32'h0, 4'h0, 0, rd, er);
    checkOutput("ld400_err", {31'd0, er}, 32'd0);
    checkOutput("ld400_rdata", rd, 32'h0000_0001);

    // Byte-enabled partial store on stack and text.
    applyStimulus("stStk", 1'b1, 32'h007F_FBFC, 32'hAABB_CCDD, 4'hF, 0, rd, er);
    applyStimulus("stStkB", 1'b1, 32'h007F_FBFC, 32'h0000_0011, 4'b0001, 0, rd, er);
    checkOutput("stStkB_err", {31'd0, er}, 32'd0);
    applyStimulus("ldStk", 1'b0, 32'h007F_FBFC, 32'h0, 4'h0, 0, rd, er);
    checkOutput("ldStk_rdata", rd, 32'hAABB_CC11);
    applyStimulus("stTxt", 1'b1, 32'h0000_0000, 32'hAABB_CCDD, 4'hF, 0, rd, er);
    applyStimulus("stTxtB", 1'b1, 32'h0000_0000, 32'h0000_0011, 4'b0001, 0, rd, er);
    applyStimulus("ldTxt", 1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, rd, er);
    checkOutput("ldTxt_rdata", rd, 32'hAABB_CC11);
    checkOutput("ldTxt_err", {31'd0, er}, 32'd0);

    // Unallocated addresses.
    applyStimulus("ld800", 1'b0, 32'h0000_0800, 32'h0, 4'h0, 0, rd, er);
    checkOutput("ld800_err", {31'd0, er}, 32'd1);
    checkOutput("ld800_rdata", rd, UNDEF);
    applyStimulus("st100000", 1'b1, 32'h0010_0000, 32'h1234_5678, 4'hF, 0, rd, er);
    checkOutput("st100000_err", {31'd0, er}, 32'd1);
    checkOutput("st100000_rdata", rd, UNDEF);
    applyStimulus("ld400b", 1'b0, 32'h0000_0400, 32'h0, 4'h0, 0, rd, er);
    checkOutput("ld400b_rdata", rd, 32'h0000_0001);
    checkOutput("ld400b_err", {31'd0, er}, 32'd0);

    // Store with no byte enables changes nothing.
    applyStimulus("stBe0", 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
    checkOutput("stBe0_err", {31'd0, er}, 32'd0);
    checkOutput("stBe0_rdata", rd, 32'h0);
    applyStimulus("ldBe0", 1'b0, 32'h0000_0400, 32'h0, 4'h0, 0, rd, er);
    checkOutput("ldBe0_rdata", rd, 32'h0000_0001);

    // Segment boundaries; last text word must not alias the first data word.
    applyStimulus("st3FC", 1'b1, 32'h0000_03FC, 32'h1234_5678, 4'hF, 0, rd, er);
    checkOutput("st3FC_err", {31'd0, er}, 32'd0);
    applyStimulus("ld3FC", 1'b0, 32'h0000_03FC, 32'h0, 4'h0, 0, rd, er);
    checkOutput("ld3FC_rdata", rd, 32'h1234_5678);
    applyStimulus("st7FC", 1'b1, 32'h0000_07FC, 32'h0BAD_F00D, 4'hF, 0, rd, er);
    checkOutput("st7FC_err", {31'd0, er}, 32'd0);
    applyStimulus("ldAlias", 1'b0, 32'h0000_0400, 32'h0, 4'h0, 0, rd, er);
    checkOutput("ldAlias_rdata", rd, 32'h0000_0001);
    applyStimulus("stStkLo", 1'b1, 32'h007F_F800, 32'hCAFE_F00D, 4'hF, 0, rd, er);
    checkOutput("stStkLo_err", {31'd0, er}, 32'd0);
    applyStimulus("ldStkLo", 1'b0, 32'h007F_F800, 32'h0, 4'h0, 0, rd, er);
    checkOutput("ldStkLo_rdata", rd, 32'hCAFE_F00D);
    applyStimulus("ldStkOut", 1'b0, 32'h007F_F7FC, 32'h0, 4'h0, 0, rd, er);
    checkOutput("ldStkOut_err", {31'd0, er}, 32'd1);
    applyStimulus("ldStkTop", 1'b0, 32'h007F_FFFC, 32'h0, 4'h0, 0, rd, er);
    checkOutput("ldStkTop_err", {31'd0, er}, 32'd0);
    applyStimulus("ld7FC", 1'b0, 32'h0000_07FC, 32'h0, 4'h0, 0, rd, er);
    checkOutput("ld7FC_rdata", rd, 32'h0BAD_F00D);

    // Back-pressure on the response channel.
    applyStimulus("hold", 1'b0, 32'h0000_0400, 32'h0, 4'h0, 5, rd, er);
    checkOutput("hold_rdata", rd, 32'h0000_0001);
    @(negedge clk);
    checkOutput("hold_postValid", {31'd0, resp_valid}, 32'd0);
    checkOutput("hold_postReqReady", {31'd0, req_ready}, 32'd1);

    // Reset during WAIT discards the pending store.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0400;
    req_wdata = 32'h5555_5555;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midRst_respValid", {31'd0, resp_valid}, 32'd0);
    checkOutput("midRst_respErr", {31'd0, resp_err}, 32'd0);
    checkOutput("midRst_respRdata", resp_rdata, 32'h0);
    checkOutput("midRst_reqReady", {31'd0, req_ready}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midRst_noResp", {31'd0, resp_valid}, 32'd0);
    applyStimulus("ldAfterRst", 1'b0, 32'h0000_0400, 32'h0, 4'h0, 0, rd, er);
    checkOutput("ldAfterRst_rdata", rd, 32'h0000_0001);
    checkOutput("ldAfterRst_err", {31'd0, er}, 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
